// File: rtl/arbt_pkg.sv
// Shared arbiter definitions: default sizing, width derivations and the entry struct
// handed from the QoS/timeout arbiter to its egress stage.
package arbt_pkg;

  localparam int ARBT_ENTRY_NUM    = 32;
  localparam int ARBT_QOS_TYPE_NUM = 16;
  localparam int ARBT_DATA_W       = 32;
  localparam int ARBT_HI_QOS_TH    = 8;

  localparam int ARBT_ID_W  = $clog2(ARBT_ENTRY_NUM);
  localparam int ARBT_QOS_W = $clog2(ARBT_QOS_TYPE_NUM);

  typedef struct packed {
    logic [ARBT_ID_W-1:0]   entry_id;
    logic [ARBT_QOS_W-1:0]  qos;
    logic [ARBT_DATA_W-1:0] payload;
  } arbt_entry_t;

endpackage

// File: rtl/arbt_egress_fifo.sv
// In-order sync FIFO for the egress stage; pointers carry an extra wrap bit so
// full/empty come straight from a pointer compare. Storage resets to zero.
module arbt_egress_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;

  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Writes only ever land in a non-head slot while not empty, so the head stays stable.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (rd_en && !empty)
      rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/arbt_egress.sv
// Arbiter egress: buffers selected entries, forwards them under credit flow control
// with a high-QoS credit reserve, and pulses an entry release one cycle after delivery.
// Optional stall counter port/logic enabled by ARBT_EGRESS_STATS_EN.
module arbt_egress
  import arbt_pkg::*;
#(
  parameter int ENTRY_NUM    = ARBT_ENTRY_NUM,
  parameter int QOS_TYPE_NUM = ARBT_QOS_TYPE_NUM,
  parameter int DATA_W       = ARBT_DATA_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int CREDIT_MAX   = 8,
  parameter int RESERVE      = 2,
  parameter int HI_QOS_TH    = ARBT_HI_QOS_TH,
  localparam int ID_W        = $clog2(ENTRY_NUM),
  localparam int QOS_W       = $clog2(QOS_TYPE_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  output logic              rdy_in,
  input  logic [ID_W-1:0]   entry_id_in,
  input  logic [QOS_W-1:0]  qos_in,
  input  logic [DATA_W-1:0] payload_in,
  output logic              vld_out,
  input  logic              rdy_out,
  output logic [ID_W-1:0]   entry_id_out,
  output logic [QOS_W-1:0]  qos_out,
  output logic [DATA_W-1:0] payload_out,
  input  logic              credit_ret,
  output logic              rel_vld,
  output logic [ID_W-1:0]   rel_entry_id,
  output logic              credit_err
`ifdef ARBT_EGRESS_STATS_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int EW = ID_W + QOS_W + DATA_W;
  localparam int CW = $clog2(CREDIT_MAX + 1);

  logic [EW-1:0] head;
  logic          full, empty;
  logic          eligible, fire, wr_en;

  logic [CW-1:0]   credit_q, credit_d;
  logic            credit_err_q, credit_err_d;
  logic            rel_vld_q, rel_vld_d;
  logic [ID_W-1:0] rel_id_q, rel_id_d;

  arbt_egress_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data ({entry_id_in, qos_in, payload_in}),
    .rd_en   (fire),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign {entry_id_out, qos_out, payload_out} = head;

  // The last RESERVE credits are held back for high-QoS heads only.
  assign eligible = (credit_q > CW'(RESERVE)) ||
                    ((credit_q >= CW'(1)) && (qos_out >= QOS_W'(HI_QOS_TH)));

  assign rdy_in  = !full;
  assign wr_en   = vld_in && !full;
  assign vld_out = !empty && eligible;
  assign fire    = vld_out && rdy_out;

  always_comb begin
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    case ({fire, credit_ret})
      2'b10: credit_d = credit_q - CW'(1);
      2'b01: begin
        if (credit_q == CW'(CREDIT_MAX)) credit_err_d = 1'b1;
        else                             credit_d     = credit_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    rel_vld_d = fire;
    rel_id_d  = fire ? entry_id_out : rel_id_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q     <= CW'(CREDIT_MAX);
      credit_err_q <= 1'b0;
      rel_vld_q    <= 1'b0;
      rel_id_q     <= '0;
    end else begin
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      rel_vld_q    <= rel_vld_d;
      rel_id_q     <= rel_id_d;
    end
  end

  assign rel_vld      = rel_vld_q;
  assign rel_entry_id = rel_id_q;
  assign credit_err   = credit_err_q;

`ifdef ARBT_EGRESS_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic        stalled;

  // Counts both credit starvation of a queued head and downstream backpressure.
  assign stalled = (!empty && !vld_out) || (vld_out && !rdy_out);

  always_comb begin
    stall_d = stall_q;
    if (stalled && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_arbt_egress.sv
// Randomized + directed bench for arbt_egress: a queue/integer reference model predicts
// handshakes, credits and releases; a negedge monitor pops the scoreboard on each delivery.
module tb_arbt_egress;
  import arbt_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld_in = 1'b0;
  logic        rdy_in;
  logic [4:0]  entry_id_in = '0;
  logic [3:0]  qos_in = '0;
  logic [31:0] payload_in = '0;
  logic        vld_out;
  logic        rdy_out = 1'b0;
  logic [4:0]  entry_id_out;
  logic [3:0]  qos_out;
  logic [31:0] payload_out;
  logic        credit_ret = 1'b0;
  logic        rel_vld;
  logic [4:0]  rel_entry_id;
  logic        credit_err;
`ifdef ARBT_EGRESS_STATS_EN
  logic [31:0] stall_cnt;
`endif

  arbt_egress dut (
    .clk          (clk),
    .rst          (rst),
    .vld_in       (vld_in),
    .rdy_in       (rdy_in),
    .entry_id_in  (entry_id_in),
    .qos_in       (qos_in),
    .payload_in   (payload_in),
    .vld_out      (vld_out),
    .rdy_out      (rdy_out),
    .entry_id_out (entry_id_out),
    .qos_out      (qos_out),
    .payload_out  (payload_out),
    .credit_ret   (credit_ret),
    .rel_vld      (rel_vld),
    .rel_entry_id (rel_entry_id),
    .credit_err   (credit_err)
`ifdef ARBT_EGRESS_STATS_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_deliv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: item queue plus an integer credit pool.
  arbt_entry_t mq[$];
  int          mcred = 8;
  bit          merr = 0;
  bit          mrel = 0;
  logic [4:0]  mrel_id = '0;
  int unsigned mstall = 0;
  bit          prev_rst = 1;

  always @(negedge clk) begin
    bit full_e, empty_e, vld_e, fire_e;
    arbt_entry_t h, n;
    if (rst) begin
      mq.delete();
      mcred = 8; merr = 0; mrel = 0; mstall = 0;
    end else begin
      if (prev_rst) begin
        chk("rst_entry_id_out", 32'(entry_id_out), 0);
        chk("rst_qos_out", 32'(qos_out), 0);
        chk("rst_payload_out", payload_out, 0);
        chk("rst_rel_entry_id", 32'(rel_entry_id), 0);
      end
      full_e  = (mq.size() == 4);
      empty_e = (mq.size() == 0);
      vld_e   = !empty_e && (mcred > 2 || (mcred >= 1 && mq[0].qos >= 4'd8));
      chk("rdy_in", 32'(rdy_in), 32'(!full_e));
      chk("vld_out", 32'(vld_out), 32'(vld_e));
      chk("credit_err", 32'(credit_err), 32'(merr));
      chk("rel_vld", 32'(rel_vld), 32'(mrel));
      if (mrel) chk("rel_entry_id", 32'(rel_entry_id), 32'(mrel_id));
`ifdef ARBT_EGRESS_STATS_EN
      chk("stall_cnt", stall_cnt, mstall);
`endif
      mrel = 1'b0;
      if (vld_out && rdy_out) begin
        if (mq.size() == 0) begin
          chk("unexpected_delivery", 32'(entry_id_out), 32'hFFFF_FFFF);
        end else begin
          h = mq.pop_front();
          chk("deliv_entry_id", 32'(entry_id_out), 32'(h.entry_id));
          chk("deliv_qos", 32'(qos_out), 32'(h.qos));
          chk("deliv_payload", payload_out, h.payload);
          mrel    = 1'b1;
          mrel_id = h.entry_id;
          n_deliv++;
        end
      end
      if (vld_in && !full_e) begin
        n.entry_id = entry_id_in; n.qos = qos_in; n.payload = payload_in;
        mq.push_back(n);
      end
      fire_e = vld_e && rdy_out;
      if (fire_e && !credit_ret) mcred--;
      else if (!fire_e && credit_ret) begin
        if (mcred == 8) merr = 1'b1;
        else            mcred++;
      end
      if ((!empty_e && !vld_e) || (vld_e && !rdy_out)) mstall++;
    end
    prev_rst = rst;
  end

  task automatic drive(input bit v, input int id, input int q, input logic [31:0] pl,
                       input bit ro, input bit cr);
    vld_in = v; entry_id_in = 5'(id); qos_in = 4'(q); payload_in = pl;
    rdy_out = ro; credit_ret = cr;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit ro);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, ro, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2, 0);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    // single item, then its release
    drive(1, 5, 3, 32'hA5A5_0001, 1, 0);
    idle(4, 1);
    // fill under backpressure, hold a fifth, then drain in order
    for (int i = 0; i < 4; i++) drive(1, i, 2, 32'h1000 + i, 0, 0);
    drive(1, 9, 2, 32'h1009, 0, 0);
    drive(1, 9, 2, 32'h1009, 0, 0);
    idle(8, 1);
    // credit depletion and head-of-line blocking
    do_reset();
    for (int i = 0; i < 6; i++) drive(1, i, 2, 32'h2000 + i, 1, 0);
    idle(3, 1);
    drive(1, 6, 2, 32'h2006, 1, 0);
    drive(1, 7, 12, 32'h2007, 1, 0);
    idle(4, 1);
    drive(0, 0, 0, 0, 1, 1);
    idle(4, 1);
    drive(1, 8, 12, 32'h2008, 1, 0);
    idle(3, 1);
    // at zero credit: return one, then fire and return together
    drive(1, 10, 12, 32'h200A, 0, 0);
    drive(1, 11, 13, 32'h200B, 0, 0);
    idle(2, 0);
    drive(0, 0, 0, 0, 0, 1);
    idle(2, 0);
    drive(0, 0, 0, 0, 1, 1);
    idle(3, 1);
    // credit return while full of credits
    do_reset();
    drive(0, 0, 0, 0, 0, 1);
    idle(3, 0);
    do_reset();
    idle(2, 0);
    // stall accounting, reset mid-burst
    drive(1, 3, 12, 32'h3003, 0, 0);
    idle(3, 0);
    for (int i = 0; i < 3; i++) drive(1, 20 + i, 1, 32'h3020 + i, 0, 0);
    idle(2, 0);
    rst = 1'b1;
    idle(1, 1);
    rst = 1'b0;
    idle(3, 1);
    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; idle(1, 0); rst = 1'b0;
      end
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 31), $urandom_range(0, 15),
            $urandom, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4);
    end
    idle(10, 1);
    chk("some_deliveries", 32'(n_deliv > 100), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arbt_egress.md
# arbt_egress

Egress stage directly downstream of the QoS/timeout entry arbiter. Accepts the arbiter's selected entry (entry id, QoS, payload) over ready/valid, buffers it in a small in-order FIFO, and forwards it to the consumer under a credit-based flow-control scheme with a credit reserve for high-QoS traffic. One cycle after each delivery it emits an entry-release pulse so the arbiter can return the slot to its free pool.

## Interface
- ENTRY_NUM, 32, arbiter entry count; ID_W = $clog2(ENTRY_NUM)
- QOS_TYPE_NUM, 16, QoS classes; QOS_W = $clog2(QOS_TYPE_NUM)
- DATA_W, 32, payload width
- FIFO_DEPTH, 4, buffer depth; power of two, ≥2
- CREDIT_MAX, 8, downstream credits at reset; ≥ RESERVE+1
- RESERVE, 2, credits usable only by high-QoS items
- HI_QOS_TH, 8, QoS ≥ this value is high priority
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- vld_in  in  1  arbiter output valid
- rdy_in  out  1  this block can accept
- entry_id_in  in  ID_W  entry selected by arbiter
- qos_in  in  QOS_W  QoS of selected entry
- payload_in  in  DATA_W  payload of selected entry
- vld_out  out  1  item offered downstream
- rdy_out  in  1  downstream accepts
- entry_id_out / qos_out / payload_out  out  ID_W / QOS_W / DATA_W  head-of-FIFO fields
- credit_ret  in  1  one credit returned per asserted cycle
- rel_vld  out  1  entry-release pulse to arbiter
- rel_entry_id  out  ID_W  entry being released
- credit_err  out  1  sticky: credit returned while counter at CREDIT_MAX
- stall_cnt  out  32  present only with ARBT_EGRESS_STATS_EN

## Operation
- FIFO: wr/rd pointers ID of $clog2(FIFO_DEPTH)+1 bits (wrap bit); full = equal index, differing wrap bit; empty = pointers equal.
- rdy_in = !full. Write on vld_in & rdy_in. No bypass: a write while empty appears at head next cycle.
- Eligibility of head: credit > RESERVE, or (credit ≥ 1 and head qos ≥ HI_QOS_TH). Strict in-order; ineligible low-QoS head blocks everything behind it.
- vld_out = !empty & eligible; combinational from registered state only, independent of rdy_out.
- Fire = vld_out & rdy_out: pop FIFO, credit −1.
- credit_ret: credit +1; fire and credit_ret same cycle → unchanged. credit_ret at CREDIT_MAX (no simultaneous fire) → ignored, credit_err set until rst.
- Full FIFO with simultaneous pop: rdy_in stays 0 that cycle (rdy_in from registered full only); write not accepted.
- rel_vld/rel_entry_id registered from fire/entry_id_out: pulse exactly one cycle after each fire, one pulse per fire, back-to-back allowed.
- Payload fields held stable while vld_out=1 and rdy_out=0.

## Timing
- Reset values: rdy_in=1, vld_out=0, entry_id_out/qos_out/payload_out=0, rel_vld=0, rel_entry_id=0, credit_err=0, credit=CREDIT_MAX, pointers=0, stall_cnt=0.
- Latency vld_in accept → vld_out: 1 cycle (credits permitting). fire → rel_vld: 1 cycle.
- Throughput: 1 item/cycle sustained when credits available.
- Credit returned in cycle N usable for eligibility in N+1.
- rst mid-operation: FIFO contents dropped, no rel_vld for dropped items; arbiter is reset by the same rst.

## Configuration
- ARBT_EGRESS_STATS_EN defined: stall_cnt port exists; increments each cycle !empty & !vld_out (credit stall) or vld_out & !rdy_out (backpressure); saturates at 2^32−1; cleared by rst.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package arbt_pkg: ID_W/QOS_W derivations, HI_QOS_TH default, packed entry struct {entry_id, qos, payload} shared with the arbiter.
- One sub-module: arbt_egress_fifo (parameterised sync FIFO, pointer wrap-bit full/empty); credit logic and release register in top.

## Test plan
- Reset then single write id=5, qos=3, payload=0xA5A5_0001, rdy_out=1 → vld_out next cycle, fire, rel_vld=1 with rel_entry_id=5 one cycle later, credit 8→7.
- Fill 4 items with rdy_out=0 → rdy_in=0 after 4th; 5th vld_in held not accepted; release rdy_out → in-order delivery ids 0,1,2,3.
- No credit_ret, 6 low-QoS (qos=2) items → 6 delivered, 7th stalls with credit=2; insert qos=12 behind it → still blocked (HOL); with qos=12 at head → 2 more delivered, credit=0, vld_out=0.
- At credit=0 pulse credit_ret same cycle as nothing else → vld_out asserts next cycle; fire + credit_ret same cycle → credit unchanged.
- credit_ret with credit=8 → credit stays 8, credit_err=1 sticky until rst.
- With ARBT_EGRESS_STATS_EN: 3 backpressure cycles + 2 credit-stall cycles → stall_cnt=5; assert rst mid-burst → stall_cnt=0, FIFO empty, no rel_vld.
